// File: rtl/operand_scoreboard_regfile_pkg.sv
// Shared types and defaults for the ID-stage operand source.
// Bank identifiers and default datapath sizes.
package operand_scoreboard_regfile_pkg;

    typedef enum logic [0:0] {
        BANK_INT   = 1'b0,
        BANK_FLOAT = 1'b1
    } bank_e;

    localparam int XLEN_D     = 32;
    localparam int NUM_REGS_D = 32;

endpackage

// File: rtl/operand_scoreboard_regfile_bank.sv
// One register bank: NUM_READ async read ports, one sync write port.
// HARDWIRE_ZERO pins index 0 to zero (integer bank).
module operand_regfile
    import operand_scoreboard_regfile_pkg::*;
#(
    parameter int XLEN          = XLEN_D,
    parameter int NUM_REGS      = NUM_REGS_D,
    parameter int NUM_READ      = 3,
    parameter bit HARDWIRE_ZERO = 1'b0,
    localparam int RW           = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [RW-1:0]            waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [NUM_READ*RW-1:0]   raddr,
    output logic [NUM_READ*XLEN-1:0] rdata
);

    logic [XLEN-1:0] regs [NUM_REGS];

    logic wr_zero;
    assign wr_zero = HARDWIRE_ZERO && (waddr == '0);

    // Clear on reset, otherwise single write port (x0 never written)
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && !wr_zero) begin
            regs[waddr] <= wdata;
        end
    end

    // Async read ports; index 0 reads zero when hardwired
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [RW-1:0] a;
        assign a = raddr[p*RW +: RW];
        assign rdata[p*XLEN +: XLEN] =
            (HARDWIRE_ZERO && a == '0) ? '0 : regs[a];
    end

endmodule

// File: rtl/operand_scoreboard_regfile.sv
// ID-stage operand source: banked regfile, write-back bypass,
// per-register pending-write scoreboard with stall/issue gating.
module operand_scoreboard_regfile
    import operand_scoreboard_regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_D,
    parameter int NUM_REGS  = NUM_REGS_D,
    parameter int NUM_BANKS = 2,
    parameter int NUM_READ  = 3,
    parameter int PEND_W    = 2,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_READ-1:0]      rd_en,
    input  logic [NUM_READ*BW-1:0]   rd_bank,
    input  logic [NUM_READ*RW-1:0]   rd_id,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic                     stall,
    input  logic                     iss_valid,
    input  logic [BW-1:0]            iss_bank,
    input  logic [RW-1:0]            iss_rd,
    output logic                     iss_ready,
    input  logic                     wb_valid,
    input  logic [BW-1:0]            wb_bank,
    input  logic [RW-1:0]            wb_id,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     flush,
    output logic                     wb_underflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [BW-1:0]     ZBANK   = BW'(BANK_INT);

    logic [PEND_W-1:0]        cnt       [NUM_BANKS][NUM_REGS];
    logic [NUM_READ*XLEN-1:0] bank_data [NUM_BANKS];

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        operand_regfile #(
            .XLEN          (XLEN),
            .NUM_REGS      (NUM_REGS),
            .NUM_READ      (NUM_READ),
            .HARDWIRE_ZERO (gb == 0)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (wb_valid && wb_bank == BW'(gb)),
            .waddr (wb_id),
            .wdata (wb_data),
            .raddr (rd_id),
            .rdata (bank_data[gb])
        );
    end

    logic iss_zero;
    logic wb_zero;
    logic iss_hit_wb;
    logic iss_acc;
    logic wb_dec;
    logic wb_cnt_zero;
    logic uf_set;

    assign iss_zero    = (iss_bank == ZBANK) && (iss_rd == '0);
    assign wb_zero     = (wb_bank == ZBANK) && (wb_id == '0);
    assign iss_hit_wb  = wb_valid && wb_bank == iss_bank
                      && wb_id == iss_rd;
    assign iss_ready   = (cnt[iss_bank][iss_rd] != CNT_MAX)
                      || iss_hit_wb;
    assign iss_acc     = iss_valid && iss_ready && !flush && !iss_zero;
    assign wb_dec      = wb_valid && !flush && !wb_zero;
    assign wb_cnt_zero = (cnt[wb_bank][wb_id] == '0);
    assign uf_set      = wb_dec && wb_cnt_zero
                      && !(iss_acc && iss_hit_wb);

    // Per-register pending counter: issue counts up, write-back down
    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_cb
        for (genvar gr = 0; gr < NUM_REGS; gr++) begin : g_cr
            logic inc;
            logic dec;
            assign inc = iss_acc && iss_bank == BW'(gb)
                      && iss_rd == RW'(gr);
            assign dec = wb_dec && wb_bank == BW'(gb)
                      && wb_id == RW'(gr);

            // Flush drops tracking; underflow is clamped at zero
            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    cnt[gb][gr] <= '0;
                end else if (inc && !dec) begin
                    cnt[gb][gr] <= cnt[gb][gr] + 1'b1;
                end else if (dec && !inc && cnt[gb][gr] != '0) begin
                    cnt[gb][gr] <= cnt[gb][gr] - 1'b1;
                end
            end
        end
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_underflow <= 1'b0;
        end else if (uf_set) begin
            wb_underflow <= 1'b1;
        end
    end

    logic [NUM_READ-1:0] haz;

    for (genvar gp = 0; gp < NUM_READ; gp++) begin : g_port
        logic [BW-1:0]     b;
        logic [RW-1:0]     r;
        logic              z;
        logic              byp;
        logic [PEND_W-1:0] c;
        assign b   = rd_bank[gp*BW +: BW];
        assign r   = rd_id[gp*RW +: RW];
        assign z   = (b == ZBANK) && (r == '0);
        assign byp = wb_valid && wb_bank == b && wb_id == r;
        assign c   = cnt[b][r];
        assign rd_data[gp*XLEN +: XLEN] =
            z   ? '0 :
            byp ? wb_data :
                  bank_data[b][gp*XLEN +: XLEN];
        assign haz[gp] = rd_en[gp] && !z && c != '0
                      && !(c == 1 && byp);
    end

    assign stall = |haz;

endmodule

// File: tb/tb_operand_scoreboard_regfile.sv
// Directed self-checking bench for operand_scoreboard_regfile.
// One task per scenario, inline comparisons.
module tb_operand_scoreboard_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_en;
    logic [2:0]  rd_bank;
    logic [14:0] rd_id;
    logic [95:0] rd_data;
    logic        stall;
    logic        iss_valid;
    logic        iss_bank;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        wb_valid;
    logic        wb_bank;
    logic [4:0]  wb_id;
    logic [31:0] wb_data;
    logic        flush;
    logic        wb_underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    operand_scoreboard_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_bank      (rd_bank),
        .rd_id        (rd_id),
        .rd_data      (rd_data),
        .stall        (stall),
        .iss_valid    (iss_valid),
        .iss_bank     (iss_bank),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_bank      (wb_bank),
        .wb_id        (wb_id),
        .wb_data      (wb_data),
        .flush        (flush),
        .wb_underflow (wb_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst       = 1'b1;
        rd_en     = '0;
        rd_bank   = '0;
        rd_id     = '0;
        iss_valid = 1'b0;
        iss_bank  = 1'b0;
        iss_rd    = '0;
        wb_valid  = 1'b0;
        wb_bank   = 1'b0;
        wb_id     = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic port(input int p, input logic b, input logic [4:0] id);
        rd_en[p]          = 1'b1;
        rd_bank[p]        = b;
        rd_id[p*5 +: 5]   = id;
    endtask

    task automatic issue(input logic b, input logic [4:0] id);
        iss_valid = 1'b1;
        iss_bank  = b;
        iss_rd    = id;
    endtask

    task automatic wb(input logic b, input logic [4:0] id, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_bank  = b;
        wb_id    = id;
        wb_data  = d;
    endtask

    function automatic logic [31:0] pd(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        wb(1'b0, 5'd4, 32'hAA);
        tick();
        idle();
        issue(1'b1, 5'd6);
        tick();
        idle();
        rst = 1'b0;
        tick();
        idle();
        #1;
        total_cnt++;
        if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready got %b exp 1", iss_ready);
        else pass_cnt++;
        total_cnt++;
        if (wb_underflow !== 1'b0) $display("FAIL reset_underflow got %b exp 0", wb_underflow);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            port(0, 1'b0, 5'(i));
            port(1, 1'b1, 5'(i));
            #1;
            total_cnt++;
            if (pd(0) !== 32'h0 || pd(1) !== 32'h0 || stall !== 1'b0)
                $display("FAIL reset_read_%0d got x=%h f=%h stall=%b exp 0/0/0",
                         i, pd(0), pd(1), stall);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_issue_wb();
        idle();
        issue(1'b0, 5'd5);
        tick();
        idle();
        port(0, 1'b0, 5'd5);
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL iss_stall got %b exp 1", stall);
        else pass_cnt++;
        tick();
        wb(1'b0, 5'd5, 32'hDEADBEEF);
        port(1, 1'b0, 5'd5);
        #1;
        total_cnt++;
        if (pd(0) !== 32'hDEADBEEF || pd(1) !== 32'hDEADBEEF)
            $display("FAIL bypass got %h/%h exp deadbeef", pd(0), pd(1));
        else pass_cnt++;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL bypass_stall got %b exp 0", stall);
        else pass_cnt++;
        tick();
        wb_valid = 1'b0;
        #1;
        total_cnt++;
        if (pd(0) !== 32'hDEADBEEF || stall !== 1'b0)
            $display("FAIL wb_array got %h stall=%b exp deadbeef/0", pd(0), stall);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_saturate();
        logic [31:0] d [3];
        d[0] = 32'h111;
        d[1] = 32'h222;
        d[2] = 32'h333;
        idle();
        issue(1'b1, 5'd3);
        tick();
        tick();
        tick();
        #1;
        total_cnt++;
        if (iss_ready !== 1'b0) $display("FAIL sat_ready got %b exp 0", iss_ready);
        else pass_cnt++;
        tick();
        iss_valid = 1'b0;
        port(0, 1'b1, 5'd3);
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL sat_stall got %b exp 1", stall);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            wb(1'b1, 5'd3, d[k]);
            #1;
            total_cnt++;
            if (stall !== (k < 2)) $display("FAIL sat_wb%0d_stall got %b exp %b", k, stall, k < 2);
            else pass_cnt++;
            if (k == 0) begin
                total_cnt++;
                if (iss_ready !== 1'b1) $display("FAIL sat_wb_ready got %b exp 1", iss_ready);
                else pass_cnt++;
            end
            tick();
        end
        wb_valid = 1'b0;
        #1;
        total_cnt++;
        if (stall !== 1'b0 || pd(0) !== 32'h333)
            $display("FAIL sat_drain got stall=%b d=%h exp 0/333", stall, pd(0));
        else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        issue(1'b0, 5'd7);
        tick();
        wb(1'b0, 5'd7, 32'h12);
        port(0, 1'b0, 5'd7);
        #1;
        total_cnt++;
        if (pd(0) !== 32'h12 || stall !== 1'b0)
            $display("FAIL b2b_bypass got %h stall=%b exp 12/0", pd(0), stall);
        else pass_cnt++;
        tick();
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL b2b_cnt got stall=%b exp 1", stall);
        else pass_cnt++;
        wb(1'b0, 5'd7, 32'h13);
        tick();
        wb_valid = 1'b0;
        #1;
        total_cnt++;
        if (stall !== 1'b0 || pd(0) !== 32'h13)
            $display("FAIL b2b_clear got stall=%b d=%h exp 0/13", stall, pd(0));
        else pass_cnt++;
        idle();
    endtask

    task automatic test_underflow();
        idle();
        total_cnt++;
        if (wb_underflow !== 1'b0) $display("FAIL uf_pre got %b exp 0", wb_underflow);
        else pass_cnt++;
        wb(1'b0, 5'd9, 32'h99);
        tick();
        idle();
        port(0, 1'b0, 5'd9);
        #1;
        total_cnt++;
        if (wb_underflow !== 1'b1 || pd(0) !== 32'h99 || stall !== 1'b0)
            $display("FAIL uf_set got flag=%b d=%h stall=%b exp 1/99/0",
                     wb_underflow, pd(0), stall);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (wb_underflow !== 1'b1) $display("FAIL uf_sticky got %b exp 1", wb_underflow);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (wb_underflow !== 1'b0 || pd(0) !== 32'h0)
            $display("FAIL uf_reset got flag=%b d=%h exp 0/0", wb_underflow, pd(0));
        else pass_cnt++;
        idle();
    endtask

    task automatic test_flush_banks();
        idle();
        issue(1'b0, 5'd1);
        tick();
        issue(1'b1, 5'd1);
        tick();
        issue(1'b0, 5'd2);
        tick();
        iss_valid = 1'b0;
        port(0, 1'b0, 5'd1);
        port(1, 1'b1, 5'd1);
        port(2, 1'b0, 5'd2);
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL fl_pre got %b exp 1", stall);
        else pass_cnt++;
        flush = 1'b1;
        issue(1'b0, 5'd3);
        tick();
        flush     = 1'b0;
        iss_valid = 1'b0;
        #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL fl_clear got %b exp 0", stall);
        else pass_cnt++;
        port(2, 1'b0, 5'd3);
        #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL fl_drop got %b exp 0", stall);
        else pass_cnt++;
        idle();
        wb(1'b0, 5'd0, 32'hFF);
        port(0, 1'b0, 5'd0);
        #1;
        total_cnt++;
        if (pd(0) !== 32'h0 || stall !== 1'b0)
            $display("FAIL x0_bypass got %h stall=%b exp 0/0", pd(0), stall);
        else pass_cnt++;
        tick();
        wb_valid = 1'b0;
        #1;
        total_cnt++;
        if (pd(0) !== 32'h0) $display("FAIL x0_array got %h exp 0", pd(0));
        else pass_cnt++;
        wb(1'b1, 5'd1, 32'hF1F1);
        tick();
        wb(1'b0, 5'd1, 32'h1111);
        tick();
        idle();
        issue(1'b1, 5'd1);
        tick();
        iss_valid = 1'b0;
        port(0, 1'b0, 5'd1);
        port(1, 1'b1, 5'd1);
        #1;
        total_cnt++;
        if (pd(0) !== 32'h1111 || pd(1) !== 32'hF1F1)
            $display("FAIL bank_data got x1=%h f1=%h exp 1111/f1f1", pd(0), pd(1));
        else pass_cnt++;
        rd_en = 3'b001;
        #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL bank_x1_stall got %b exp 0", stall);
        else pass_cnt++;
        rd_en = 3'b010;
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL bank_f1_stall got %b exp 1", stall);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_issue_wb();
        test_saturate();
        test_back_to_back();
        test_underflow();
        test_flush_banks();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
